// File: rtl/hs_sink_fifo.sv
// Consumer end of a four-phase ready/done handshake feeding a first-word fall-through FIFO.
// One word is captured per handshake; pops are independent and underflow is sticky.
module hs_sink_fifo #(
  parameter int unsigned DATA_BITWIDTH = 8,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned CNT_BITS      = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_BITWIDTH-1:0] data_in,
  input  logic                     ready_in,
  output logic                     done_in,
  input  logic                     rd_en,
  output logic [DATA_BITWIDTH-1:0] rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [CNT_BITS-1:0]      count,
  output logic                     err_underflow
);

  localparam int unsigned PtrBits = $clog2(DEPTH);

  typedef enum logic [0:0] {
    StIdle,
    StAck
  } state_e;

  state_e                     r_state;
  state_e                     w_state_next;
  logic [DATA_BITWIDTH-1:0]   r_mem [DEPTH];
  logic [PtrBits-1:0]         r_wr_ptr;
  logic [PtrBits-1:0]         r_rd_ptr;
  logic [CNT_BITS-1:0]        r_count;
  logic                       r_err_underflow;
  logic                       w_wr;
  logic                       w_rd;

  // Full is taken from the registered count, so a pop on a full FIFO defers the write one edge.
  assign w_wr = (r_state == StIdle) && ready_in && !full;
  assign w_rd = rd_en && !empty;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_wr) w_state_next = StAck;
      StAck:   if (!ready_in) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PtrBits'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PtrBits'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_BITS'(1);
        2'b01:   r_count <= r_count - CNT_BITS'(1);
        default: r_count <= r_count;
      endcase
      if (rd_en && empty) r_err_underflow <= 1'b1;
    end
  end

  assign done_in       = (r_state == StAck);
  assign rd_data       = r_mem[r_rd_ptr];
  assign count         = r_count;
  assign empty         = (r_count == '0);
  assign full          = (r_count == CNT_BITS'(DEPTH));
  assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_hs_sink_fifo.sv
// Bench for hs_sink_fifo: directed vector table, reset corner cases, then a randomized
// producer/consumer run checked against a queue-based model.
module tb_hs_sink_fifo;

  localparam int unsigned Depth = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       ready_in;
  logic       done_in;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       err_underflow;

  int n_checks = 0;
  int n_err    = 0;

  hs_sink_fifo #(
    .DATA_BITWIDTH(8),
    .DEPTH        (Depth),
    .CNT_BITS     (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .ready_in     (ready_in),
    .done_in      (done_in),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic [7:0] din;
    logic       rd;
    logic       done;
    logic [2:0] cnt;
    logic       emp;
    logic       ful;
    logic       err;
    logic       chkd;
    logic [7:0] rdata;
  } vec_t;

  vec_t vq[$];

  task automatic av(input logic rdy, input logic [7:0] din, input logic rd, input logic done,
                    input logic [2:0] cnt, input logic emp, input logic ful, input logic err,
                    input logic chkd, input logic [7:0] rdata);
    vec_t v;
    v.rdy = rdy; v.din = din; v.rd = rd; v.done = done; v.cnt = cnt;
    v.emp = emp; v.ful = ful; v.err = err; v.chkd = chkd; v.rdata = rdata;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic done, input logic [2:0] cnt,
                          input logic emp, input logic ful, input logic err,
                          input logic chkd, input logic [7:0] rdata);
    chk({tag, ".done_in"}, 32'(done_in), 32'(done));
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".empty"}, 32'(empty), 32'(emp));
    chk({tag, ".full"}, 32'(full), 32'(ful));
    chk({tag, ".err_underflow"}, 32'(err_underflow), 32'(err));
    if (chkd) chk({tag, ".rd_data"}, 32'(rd_data), 32'(rdata));
  endtask

  // Reference model state
  logic [7:0] m_q[$];
  logic       m_ack;
  logic       m_err;

  initial begin
    // rdy din rd | done cnt emp ful err chkd rdata
    av(H, 8'hA5, L, H, 3'd1, L, L, L, H, 8'hA5);
    av(L, 8'hA5, L, L, 3'd1, L, L, L, H, 8'hA5);
    av(L, 8'hA5, H, L, 3'd0, H, L, L, L, 8'h00);
    av(L, 8'h00, H, L, 3'd0, H, L, H, L, 8'h00);
    av(H, 8'h01, L, H, 3'd1, L, L, H, H, 8'h01);
    av(L, 8'h01, L, L, 3'd1, L, L, H, H, 8'h01);
    av(H, 8'h02, L, H, 3'd2, L, L, H, H, 8'h01);
    av(L, 8'h02, L, L, 3'd2, L, L, H, H, 8'h01);
    av(H, 8'h03, L, H, 3'd3, L, L, H, H, 8'h01);
    av(L, 8'h03, L, L, 3'd3, L, L, H, H, 8'h01);
    av(H, 8'h04, L, H, 3'd4, L, H, H, H, 8'h01);
    av(L, 8'h04, L, L, 3'd4, L, H, H, H, 8'h01);
    av(H, 8'h05, L, L, 3'd4, L, H, H, H, 8'h01);
    av(H, 8'h05, L, L, 3'd4, L, H, H, H, 8'h01);
    av(H, 8'h05, H, L, 3'd3, L, L, H, H, 8'h02);
    av(H, 8'h05, L, H, 3'd4, L, H, H, H, 8'h02);
    av(H, 8'h05, L, H, 3'd4, L, H, H, H, 8'h02);
    av(L, 8'h05, L, L, 3'd4, L, H, H, H, 8'h02);
    av(L, 8'h05, H, L, 3'd3, L, L, H, H, 8'h03);
    av(L, 8'h05, H, L, 3'd2, L, L, H, H, 8'h04);
    av(L, 8'h05, H, L, 3'd1, L, L, H, H, 8'h05);
    av(L, 8'h05, H, L, 3'd0, H, L, H, L, 8'h00);
    av(H, 8'h77, H, H, 3'd1, L, L, H, H, 8'h77);
    av(L, 8'h77, L, L, 3'd1, L, L, H, H, 8'h77);

    rst_n    = 1'b0;
    ready_in = 1'b0;
    data_in  = 8'h00;
    rd_en    = 1'b0;
    #3;
    chk_outs("reset", L, 3'd0, H, L, L, H, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vq[i]) begin
      ready_in = vq[i].rdy;
      data_in  = vq[i].din;
      rd_en    = vq[i].rd;
      @(posedge clk);
      #1;
      chk_outs($sformatf("vec%0d", i), vq[i].done, vq[i].cnt, vq[i].emp, vq[i].ful,
               vq[i].err, vq[i].chkd, vq[i].rdata);
    end

    // Reach ACK with two entries, then reset mid-handshake while ready_in stays high.
    ready_in = 1'b1;
    data_in  = 8'h88;
    rd_en    = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("pre_rst", H, 3'd2, L, L, H, H, 8'h77);
    rst_n = 1'b0;
    #1;
    chk_outs("mid_rst", L, 3'd0, H, L, L, H, 8'h00);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_outs("post_rst", H, 3'd1, L, L, L, H, 8'h88);

    m_q   = {8'h88};
    m_ack = 1'b1;
    m_err = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      int unsigned bias;
      logic        wr;
      logic        rd;
      bias = 20 + 15 * ((c / 400) % 4);
      if (!ready_in && !m_ack) begin
        if ($urandom_range(1, 0) == 1) begin
          ready_in = 1'b1;
          data_in  = 8'($urandom);
        end
      end else if (ready_in && m_ack) begin
        if ($urandom_range(2, 0) != 0) ready_in = 1'b0;
      end
      rd_en = ($urandom_range(99, 0) < bias);

      wr = !m_ack && ready_in && (m_q.size() < Depth);
      rd = rd_en && (m_q.size() > 0);
      if (rd_en && m_q.size() == 0) m_err = 1'b1;
      if (rd) void'(m_q.pop_front());
      if (wr) m_q.push_back(data_in);
      m_ack = m_ack ? ready_in : wr;

      @(posedge clk);
      #1;
      chk_outs($sformatf("rnd%0d", c), m_ack, 3'(m_q.size()), (m_q.size() == 0),
               (m_q.size() == Depth), m_err, (m_q.size() != 0),
               (m_q.size() != 0) ? m_q[0] : 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
